// File: rtl/axil_slave_regmem.sv
// AXI4-Lite slave word memory: DEPTH x 32-bit words, byte strobes, one outstanding write and one outstanding read.
// Define AXIL_OOR_SLVERR_EN to answer out-of-range accesses with SLVERR; otherwise the word index wraps modulo DEPTH.
//
// state     | meaning
// W_COLLECT | gathering AW and W in any order; a captured channel holds its READY low
// W_RESP    | write committed, BVALID/BRESP held until BREADY
// R_ADDR    | ARREADY high, waiting for a read address
// R_DATA    | RDATA/RRESP/RVALID held until RREADY
module axil_slave_regmem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WORD_W = ADDR_W - 2;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} w_state_t;
  typedef enum logic {R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] aw_addr_q, aw_addr_n;
  logic [DATA_W-1:0] w_data_q, w_data_n;
  logic [STRB_W-1:0] w_strb_q, w_strb_n;
  logic              awready_n, wready_n, bvalid_n;
  logic [1:0]        bresp_n;
  logic              arready_n, rvalid_n;
  logic [DATA_W-1:0] rdata_n;
  logic [1:0]        rresp_n;

  logic              aw_fire, w_fire, ar_fire, mem_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [WORD_W-1:0] wr_word, rd_word;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              wr_ok, rd_ok;
  logic              unused_addr_bits;

  assign aw_fire = S_AXI_AWREADY & S_AXI_AWVALID;
  assign w_fire  = S_AXI_WREADY & S_AXI_WVALID;
  assign ar_fire = S_AXI_ARREADY & S_AXI_ARVALID;

  // While READY is high nothing is held, so the live bus value is the one being captured.
  assign wr_addr = S_AXI_AWREADY ? S_AXI_AWADDR : aw_addr_q;
  assign wr_data = S_AXI_WREADY ? S_AXI_WDATA : w_data_q;
  assign wr_strb = S_AXI_WREADY ? S_AXI_WSTRB : w_strb_q;

  assign wr_word = wr_addr[ADDR_W-1:2];
  assign rd_word = S_AXI_ARADDR[ADDR_W-1:2];
  assign wr_idx  = wr_word[IDX_W-1:0];
  assign rd_idx  = rd_word[IDX_W-1:0];

`ifdef AXIL_OOR_SLVERR_EN
  assign wr_ok = ({1'b0, wr_word} < (WORD_W+1)'(DEPTH));
  assign rd_ok = ({1'b0, rd_word} < (WORD_W+1)'(DEPTH));
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  assign unused_addr_bits = ^{wr_addr[1:0], S_AXI_ARADDR[1:0], wr_word, rd_word};

  always_comb begin
    w_state_n = w_state;
    awready_n = S_AXI_AWREADY;
    wready_n  = S_AXI_WREADY;
    bvalid_n  = S_AXI_BVALID;
    bresp_n   = S_AXI_BRESP;
    aw_addr_n = aw_addr_q;
    w_data_n  = w_data_q;
    w_strb_n  = w_strb_q;
    mem_we    = 1'b0;
    case (w_state)
      W_COLLECT: begin
        if (aw_fire) begin
          awready_n = 1'b0;
          aw_addr_n = S_AXI_AWADDR;
        end
        if (w_fire) begin
          wready_n = 1'b0;
          w_data_n = S_AXI_WDATA;
          w_strb_n = S_AXI_WSTRB;
        end
        if ((aw_fire | ~S_AXI_AWREADY) & (w_fire | ~S_AXI_WREADY)) begin
          mem_we    = wr_ok;
          bvalid_n  = 1'b1;
          bresp_n   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          w_state_n = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          w_state_n = W_COLLECT;
        end
      end
      default: w_state_n = W_COLLECT;
    endcase
  end

  // Read data is taken from the registered array, so a same-edge write commit is not yet visible.
  always_comb begin
    r_state_n = r_state;
    arready_n = S_AXI_ARREADY;
    rvalid_n  = S_AXI_RVALID;
    rdata_n   = S_AXI_RDATA;
    rresp_n   = S_AXI_RRESP;
    case (r_state)
      R_ADDR: begin
        if (ar_fire) begin
          rdata_n   = rd_ok ? mem[rd_idx] : '0;
          rresp_n   = rd_ok ? RESP_OKAY : RESP_SLVERR;
          rvalid_n  = 1'b1;
          arready_n = 1'b0;
          r_state_n = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          r_state_n = R_ADDR;
        end
      end
      default: r_state_n = R_ADDR;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state       <= W_COLLECT;
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY  <= 1'b1;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      w_state       <= w_state_n;
      S_AXI_AWREADY <= awready_n;
      S_AXI_WREADY  <= wready_n;
      S_AXI_BVALID  <= bvalid_n;
      S_AXI_BRESP   <= bresp_n;
      aw_addr_q     <= aw_addr_n;
      w_data_q      <= w_data_n;
      w_strb_q      <= w_strb_n;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state       <= R_ADDR;
      S_AXI_ARREADY <= 1'b1;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      r_state       <= r_state_n;
      S_AXI_ARREADY <= arready_n;
      S_AXI_RVALID  <= rvalid_n;
      S_AXI_RDATA   <= rdata_n;
      S_AXI_RRESP   <= rresp_n;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < STRB_W; b++)
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

endmodule
